// File: rtl/video_mode_sender_if.sv
// Request side of the video-mode byte link: valid/ready handshake carrying
// the 2-bit mode selector (0=VGA, 1=720p, 2=1080p, 3=invalid).
interface video_mode_sender_if;
    logic       req_valid;
    logic [1:0] req_mode;
    logic       req_ready;

    modport master (output req_valid, output req_mode, input req_ready);
    modport slave  (input req_valid, input req_mode, output req_ready);
endinterface

// File: rtl/video_mode_sender.sv
// video_mode_sender: transmit side of the 8-bit video-mode byte link.
// Each accepted request drives IDLE_CODE for GAP_CYCLES, then the mode code
// for HOLD_CYCLES, so even a repeated mode produces a visible byte change.
// Optional feature macro: VIDEO_MODE_BUTTON_EN adds a debounced btn_next
// input that requests the mode following current_mode (0->1->2->0).
`ifndef MODE_VGA
`define MODE_VGA   8'h01
`endif
`ifndef MODE_720p
`define MODE_720p  8'h02
`endif
`ifndef MODE_1080p
`define MODE_1080p 8'h03
`endif

module video_mode_sender #(
    parameter int unsigned GAP_CYCLES      = 4,
    parameter int unsigned HOLD_CYCLES     = 16,
    parameter logic [7:0]  IDLE_CODE       = 8'h00,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic                clock,
    input  logic                reset_n,
    video_mode_sender_if.slave  req,
`ifdef VIDEO_MODE_BUTTON_EN
    input  logic                btn_next,
`endif
    output logic [7:0]          data_out,
    output logic [1:0]          current_mode,
    output logic                done,
    output logic                err_invalid
);

    localparam int unsigned MAX_CYCLES = (GAP_CYCLES > HOLD_CYCLES) ? GAP_CYCLES : HOLD_CYCLES;
    localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] GAP_LD   = CW'(GAP_CYCLES);
    localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYCLES);

    typedef enum logic [1:0] {ST_IDLE, ST_GAP, ST_HOLD} state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [1:0]    mode_q, mode_next;
    logic [7:0]    data_next;
    logic [1:0]    cur_next;
    logic          done_next, err_next, ready_q, ready_next;
    logic          take_ext, take_btn, btn_req;

    function automatic logic [7:0] mode_code(input logic [1:0] m);
        case (m)
            2'd0:    mode_code = `MODE_VGA;
            2'd1:    mode_code = `MODE_720p;
            default: mode_code = `MODE_1080p;
        endcase
    endfunction

`ifdef VIDEO_MODE_BUTTON_EN
    localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    btn_sync;
    logic          btn_db;
    logic [DW-1:0] db_cnt;

    // Two-flop synchroniser for the raw button level.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) btn_sync <= '0;
        else          btn_sync <= {btn_sync[0], btn_next};
    end

    // Debounce: accept a new level once it has differed for DEBOUNCE_CYCLES samples; pulse on rise.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            btn_db  <= 1'b0;
            db_cnt  <= '0;
            btn_req <= 1'b0;
        end else begin
            btn_req <= 1'b0;
            if (btn_sync[1] == btn_db) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                btn_db  <= btn_sync[1];
                db_cnt  <= '0;
                btn_req <= btn_sync[1];
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end
`else
    logic unused_debounce_cfg;
    assign unused_debounce_cfg = ^DEBOUNCE_CYCLES;
    assign btn_req             = 1'b0;
`endif

    assign req.req_ready = ready_q;
    assign take_ext      = req.req_valid & ready_q;
    assign take_btn      = btn_req & ready_q & ~req.req_valid;

    // Next-state and registered-output logic for the IDLE/GAP/HOLD sequencer.
    always_comb begin
        state_next = state;
        cnt_next   = (cnt != '0) ? cnt - 1'b1 : cnt;
        mode_next  = mode_q;
        data_next  = data_out;
        cur_next   = current_mode;
        done_next  = 1'b0;
        err_next   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (take_ext) begin
                    if (req.req_mode == 2'd3) begin
                        err_next = 1'b1;
                    end else begin
                        state_next = ST_GAP;
                        cnt_next   = GAP_LD;
                        mode_next  = req.req_mode;
                    end
                end else if (take_btn) begin
                    state_next = ST_GAP;
                    cnt_next   = GAP_LD;
                    mode_next  = (current_mode == 2'd2) ? 2'd0 : current_mode + 2'd1;
                end
            end
            ST_GAP: begin
                data_next = IDLE_CODE;
                if (cnt <= 1) begin
                    state_next = ST_HOLD;
                    cnt_next   = HOLD_LD;
                end
            end
            ST_HOLD: begin
                data_next = mode_code(mode_q);
                if (cnt <= 1) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                    cur_next   = mode_q;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        ready_next = (state_next == ST_IDLE);
    end

    // State, counter and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            mode_q       <= 2'd0;
            data_out     <= `MODE_VGA;
            current_mode <= 2'd0;
            done         <= 1'b0;
            err_invalid  <= 1'b0;
            ready_q      <= 1'b1;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            mode_q       <= mode_next;
            data_out     <= data_next;
            current_mode <= cur_next;
            done         <= done_next;
            err_invalid  <= err_next;
            ready_q      <= ready_next;
        end
    end

endmodule

// File: tb/tb_video_mode_sender.sv
// Directed bench for video_mode_sender with GAP=2, HOLD=4, DEBOUNCE=8.
`ifndef MODE_VGA
`define MODE_VGA   8'h01
`endif
`ifndef MODE_720p
`define MODE_720p  8'h02
`endif
`ifndef MODE_1080p
`define MODE_1080p 8'h03
`endif

module tb_video_mode_sender;

    localparam int unsigned GAP  = 2;
    localparam int unsigned HOLD = 4;
    localparam int unsigned DB   = 8;
    localparam logic [7:0] IDLE_C  = 8'h00;
    localparam logic [7:0] VGA_C   = `MODE_VGA;
    localparam logic [7:0] P720_C  = `MODE_720p;
    localparam logic [7:0] P1080_C = `MODE_1080p;

    logic       clock   = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] data_out;
    logic [1:0] current_mode;
    logic       done;
    logic       err_invalid;
`ifdef VIDEO_MODE_BUTTON_EN
    logic       btn_next = 1'b0;
`endif

    int unsigned errors = 0;
    int unsigned checks = 0;

    video_mode_sender_if req_if();

    video_mode_sender #(
        .GAP_CYCLES(GAP),
        .HOLD_CYCLES(HOLD),
        .IDLE_CODE(IDLE_C),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .req(req_if),
`ifdef VIDEO_MODE_BUTTON_EN
        .btn_next(btn_next),
`endif
        .data_out(data_out),
        .current_mode(current_mode),
        .done(done),
        .err_invalid(err_invalid)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    function automatic logic [7:0] code_of(input logic [1:0] m);
        case (m)
            2'd0:    code_of = VGA_C;
            2'd1:    code_of = P720_C;
            default: code_of = P1080_C;
        endcase
    endfunction

    // One complete request: accept, GAP, HOLD, done pulse.
    task automatic run_req(input logic [1:0] m, input logic [7:0] prev);
        req_if.req_valid = 1'b1;
        req_if.req_mode  = m;
        check("ready_before", 32'(req_if.req_ready), 32'(1));
        tick;
        req_if.req_valid = 1'b0;
        check("ready_drop", 32'(req_if.req_ready), 32'(0));
        check("data_at_accept", 32'(data_out), 32'(prev));
        for (int i = 0; i < int'(GAP); i++) begin
            tick;
            check("gap_code", 32'(data_out), 32'(IDLE_C));
            check("gap_ready", 32'(req_if.req_ready), 32'(0));
        end
        for (int i = 0; i < int'(HOLD) - 1; i++) begin
            tick;
            check("hold_code", 32'(data_out), 32'(code_of(m)));
            check("hold_done", 32'(done), 32'(0));
            check("hold_ready", 32'(req_if.req_ready), 32'(0));
        end
        tick;
        check("done_pulse", 32'(done), 32'(1));
        check("cur_mode", 32'(current_mode), 32'(m));
        check("ready_back", 32'(req_if.req_ready), 32'(1));
        check("data_end", 32'(data_out), 32'(code_of(m)));
        tick;
        check("done_clear", 32'(done), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef VIDEO_MODE_BUTTON_EN
        logic busy;
`endif
        req_if.req_valid = 1'b0;
        req_if.req_mode  = 2'd0;
        tick;
        tick;
        check("rst_data", 32'(data_out), 32'(VGA_C));
        reset_n = 1'b1;
        tick;
        check("rst_data_rel", 32'(data_out), 32'(VGA_C));
        check("rst_ready", 32'(req_if.req_ready), 32'(1));
        check("rst_cur", 32'(current_mode), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_err", 32'(err_invalid), 32'(0));

        // 720p request
        run_req(2'd1, VGA_C);

        // invalid request
        req_if.req_valid = 1'b1;
        req_if.req_mode  = 2'd3;
        tick;
        req_if.req_valid = 1'b0;
        check("inv_err", 32'(err_invalid), 32'(1));
        check("inv_data", 32'(data_out), 32'(P720_C));
        check("inv_ready", 32'(req_if.req_ready), 32'(1));
        tick;
        check("inv_err_clear", 32'(err_invalid), 32'(0));
        check("inv_data2", 32'(data_out), 32'(P720_C));
        check("inv_cur", 32'(current_mode), 32'(1));

        // same mode again still runs the full gap
        run_req(2'd1, P720_C);

        // valid held high: 1080p then VGA
        req_if.req_valid = 1'b1;
        req_if.req_mode  = 2'd2;
        tick;
        check("held_ready_drop", 32'(req_if.req_ready), 32'(0));
        req_if.req_mode = 2'd0;
        for (int i = 0; i < int'(GAP); i++) begin
            tick;
            check("held_gap1", 32'(data_out), 32'(IDLE_C));
        end
        for (int i = 0; i < int'(HOLD) - 1; i++) begin
            tick;
            check("held_hold1", 32'(data_out), 32'(P1080_C));
            check("held_busy", 32'(req_if.req_ready), 32'(0));
        end
        tick;
        check("held_done1", 32'(done), 32'(1));
        check("held_cur1", 32'(current_mode), 32'(2));
        check("held_ready1", 32'(req_if.req_ready), 32'(1));
        tick;
        req_if.req_valid = 1'b0;
        check("held_accept2", 32'(req_if.req_ready), 32'(0));
        check("held_data_acc2", 32'(data_out), 32'(P1080_C));
        for (int i = 0; i < int'(GAP); i++) begin
            tick;
            check("held_gap2", 32'(data_out), 32'(IDLE_C));
        end
        tick;
        check("held_hold2", 32'(data_out), 32'(VGA_C));
        repeat (HOLD - 1) tick;
        check("held_done2", 32'(done), 32'(1));
        check("held_cur2", 32'(current_mode), 32'(0));
        tick;

        run_req(2'd1, VGA_C);

        // reset during HOLD of 1080p
        req_if.req_valid = 1'b1;
        req_if.req_mode  = 2'd2;
        tick;
        req_if.req_valid = 1'b0;
        repeat (GAP + 2) tick;
        check("mid_hold_data", 32'(data_out), 32'(P1080_C));
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_data", 32'(data_out), 32'(VGA_C));
        check("async_rst_cur", 32'(current_mode), 32'(0));
        check("async_rst_ready", 32'(req_if.req_ready), 32'(1));
        @(negedge clock);
        reset_n = 1'b1;
        repeat (HOLD + 2) tick;
        check("post_rst_data", 32'(data_out), 32'(VGA_C));
        check("post_rst_cur", 32'(current_mode), 32'(0));
        check("post_rst_done", 32'(done), 32'(0));

`ifdef VIDEO_MODE_BUTTON_EN
        // short glitch must not create a request
        btn_next = 1'b1;
        repeat (3) tick;
        btn_next = 1'b0;
        busy = 1'b0;
        repeat (20) begin
            tick;
            if (!req_if.req_ready) busy = 1'b1;
        end
        check("glitch_no_req", 32'(busy), 32'(0));
        check("glitch_data", 32'(data_out), 32'(VGA_C));

        // long press from 1080p wraps to VGA
        run_req(2'd2, VGA_C);
        btn_next = 1'b1;
        repeat (20) tick;
        btn_next = 1'b0;
        repeat (30) tick;
        check("btn_data", 32'(data_out), 32'(VGA_C));
        check("btn_cur", 32'(current_mode), 32'(0));
        check("btn_ready", 32'(req_if.req_ready), 32'(1));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
